msrv32_dmem_access_ctrl: RTL and testbench

//  Sequences every RV32I load/store onto the single-port data-memory bus and feeds the load unit.

---
 rtl/msrv32_lsu_pkg.sv | 21 ++
 rtl/msrv32_store_align.sv | 37 +++
 rtl/msrv32_dmem_access_ctrl.sv | 167 ++++++++++++++++
 tb/tb_msrv32_dmem_access_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_lsu_pkg.sv
// Shared FSM state codes, access-size codes and byte-lane mask constants
// for the RV32I data-memory access path.
package msrv32_lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } dmem_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

endpackage

// File: rtl/msrv32_store_align.sv
// Combinational byte-lane mask, store-data replication and alignment check
// for one load/store request.
module msrv32_store_align
  import msrv32_lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       size_in,
  input  logic [1:0]       offset_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [3:0]       mask_out,
  output logic [WIDTH-1:0] data_out,
  output logic             misaligned_out
);

  always_comb begin
    mask_out       = MASK_WORD;
    data_out       = data_in;
    misaligned_out = 1'b0;
    case (size_in)
      SZ_BYTE: begin
        mask_out = MASK_BYTE << offset_in;
        data_out = {(WIDTH/8){data_in[7:0]}};
      end
      SZ_HALF: begin
        mask_out       = MASK_HALF << {offset_in[1], 1'b0};
        data_out       = {(WIDTH/16){data_in[15:0]}};
        misaligned_out = offset_in[0];
      end
      // Size code 11 behaves exactly like a word access.
      default: begin
        misaligned_out = (offset_in != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/msrv32_dmem_access_ctrl.sv
// Data-memory access sequencer: IDLE/BUSY/DONE/ERR around a single-port bus.
// Define MSRV32_DMEM_TIMEOUT_EN to add a BUSY watchdog that raises bus_err_out.
module msrv32_dmem_access_ctrl
  import msrv32_lsu_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             ms_riscv32_mp_clk_in,
  input  logic             ms_riscv32_mp_rst_in,
  input  logic             load_req_in,
  input  logic             store_req_in,
  input  logic [WIDTH-1:0] addr_in,
  input  logic [WIDTH-1:0] store_data_in,
  input  logic [1:0]       size_in,
  input  logic             load_unsigned_in,
  input  logic [WIDTH-1:0] ms_riscv32_mp_dmdata_in,
  input  logic             ms_riscv32_mp_hready_in,
  output logic [WIDTH-1:0] ms_riscv32_mp_dmaddr_out,
  output logic [WIDTH-1:0] ms_riscv32_mp_dmdata_out,
  output logic             ms_riscv32_mp_dmrd_req_out,
  output logic             ms_riscv32_mp_dmwr_req_out,
  output logic [3:0]       ms_riscv32_mp_dmwr_mask_out,
  output logic [WIDTH-1:0] lu_data_out,
  output logic [1:0]       load_size_out,
  output logic             load_unsigned_out,
  output logic [1:0]       iadder_out_1_to_0_out,
  output logic             stall_out,
  output logic             done_out,
  output logic             misaligned_out,
  output logic             bus_err_out
);

  dmem_state_e      state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] lu_data_q, lu_data_d;
  logic [3:0]       mask_q, mask_d;
  logic [1:0]       size_q, size_d;
  logic             unsigned_q, unsigned_d;
  logic             store_q, store_d;
  logic             any_req;
  logic [3:0]       al_mask;
  logic [WIDTH-1:0] al_data;
  logic             al_misaligned;

  assign any_req = load_req_in | store_req_in;

  msrv32_store_align #(.WIDTH(WIDTH)) u_store_align (
    .size_in        (size_in),
    .offset_in      (addr_in[1:0]),
    .data_in        (store_data_in),
    .mask_out       (al_mask),
    .data_out       (al_data),
    .misaligned_out (al_misaligned)
  );

`ifdef MSRV32_DMEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    lu_data_d  = lu_data_q;
    mask_d     = mask_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    store_d    = store_q;
`ifdef MSRV32_DMEM_TIMEOUT_EN
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          // A simultaneous load and store request resolves to the store.
          addr_d     = addr_in;
          wdata_d    = al_data;
          size_d     = size_in;
          unsigned_d = load_unsigned_in;
          store_d    = store_req_in;
          mask_d     = store_req_in ? al_mask : MASK_NONE;
          state_d    = al_misaligned ? ST_ERR : ST_BUSY;
`ifdef MSRV32_DMEM_TIMEOUT_EN
          cnt_d      = '0;
          tmo_d      = 1'b0;
`endif
        end
      end
      ST_BUSY: begin
        if (ms_riscv32_mp_hready_in) begin
          if (!store_q) lu_data_d = ms_riscv32_mp_dmdata_in;
          state_d = ST_DONE;
        end
`ifdef MSRV32_DMEM_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d = ST_ERR;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      lu_data_q  <= '0;
      mask_q     <= MASK_NONE;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      store_q    <= 1'b0;
`ifdef MSRV32_DMEM_TIMEOUT_EN
      cnt_q      <= '0;
      tmo_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      lu_data_q  <= lu_data_d;
      mask_q     <= mask_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      store_q    <= store_d;
`ifdef MSRV32_DMEM_TIMEOUT_EN
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
`endif
    end
  end

  // Bus strobes decode straight from state so an async reset drops them at once.
  assign ms_riscv32_mp_dmaddr_out    = {addr_q[WIDTH-1:2], 2'b00};
  assign ms_riscv32_mp_dmdata_out    = wdata_q;
  assign ms_riscv32_mp_dmrd_req_out  = (state_q == ST_BUSY) & ~store_q;
  assign ms_riscv32_mp_dmwr_req_out  = (state_q == ST_BUSY) & store_q;
  assign ms_riscv32_mp_dmwr_mask_out = (state_q == ST_BUSY) ? mask_q : MASK_NONE;
  assign lu_data_out                 = lu_data_q;
  assign load_size_out               = size_q;
  assign load_unsigned_out           = unsigned_q;
  assign iadder_out_1_to_0_out       = addr_q[1:0];
  assign stall_out = ((state_q == ST_IDLE) & any_req) | (state_q == ST_BUSY) | (state_q == ST_ERR);
  assign done_out  = (state_q == ST_DONE);

`ifdef MSRV32_DMEM_TIMEOUT_EN
  assign misaligned_out = (state_q == ST_ERR) & ~tmo_q;
  assign bus_err_out    = (state_q == ST_ERR) & tmo_q;
`else
  assign misaligned_out = (state_q == ST_ERR);
  assign bus_err_out    = 1'b0;
`endif

endmodule

// File: tb/tb_msrv32_dmem_access_ctrl.sv
// Self-checking bench for msrv32_dmem_access_ctrl: directed vector table,
// reset/timeout sequences and randomized transactions against a reference model.
module tb_msrv32_dmem_access_ctrl;

`ifdef MSRV32_DMEM_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_req_in, store_req_in, load_unsigned_in, hready_in;
  logic [31:0] addr_in, store_data_in, dmdata_in;
  logic [1:0]  size_in;
  logic [31:0] dmaddr_out, dmdata_out, lu_data_out;
  logic        rd_req_out, wr_req_out, load_unsigned_out;
  logic [3:0]  mask_out;
  logic [1:0]  load_size_out, iadder_out;
  logic        stall_out, done_out, misaligned_out, bus_err_out;

  always #5 clk = ~clk;

  msrv32_dmem_access_ctrl #(.WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .ms_riscv32_mp_clk_in        (clk),
    .ms_riscv32_mp_rst_in        (rst),
    .load_req_in                 (load_req_in),
    .store_req_in                (store_req_in),
    .addr_in                     (addr_in),
    .store_data_in               (store_data_in),
    .size_in                     (size_in),
    .load_unsigned_in            (load_unsigned_in),
    .ms_riscv32_mp_dmdata_in     (dmdata_in),
    .ms_riscv32_mp_hready_in     (hready_in),
    .ms_riscv32_mp_dmaddr_out    (dmaddr_out),
    .ms_riscv32_mp_dmdata_out    (dmdata_out),
    .ms_riscv32_mp_dmrd_req_out  (rd_req_out),
    .ms_riscv32_mp_dmwr_req_out  (wr_req_out),
    .ms_riscv32_mp_dmwr_mask_out (mask_out),
    .lu_data_out                 (lu_data_out),
    .load_size_out               (load_size_out),
    .load_unsigned_out           (load_unsigned_out),
    .iadder_out_1_to_0_out       (iadder_out),
    .stall_out                   (stall_out),
    .done_out                    (done_out),
    .misaligned_out              (misaligned_out),
    .bus_err_out                 (bus_err_out)
  );

  typedef struct {
    bit          ld;
    bit          st;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    bit          uns;
    int          dly;
    logic [31:0] rdata;
    logic [3:0]  emask;
    logic [31:0] ewdata;
    bit          emis;
  } vec_t;

  int          n_checks = 0;
  int          n_err    = 0;
  string       cur      = "init";
  logic [31:0] exp_lu   = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got %h expected %h", cur, name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got %b expected %b", cur, name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load_req_in = 1'b0; store_req_in = 1'b0; addr_in = 32'h0; store_data_in = 32'h0;
    size_in = 2'b00; load_unsigned_in = 1'b0; hready_in = 1'b0; dmdata_in = 32'h0;
  endtask

  // Garbage on every input while the controller is not accepting requests.
  task automatic junk_inputs();
    load_req_in = 1'($urandom); store_req_in = 1'($urandom); addr_in = $urandom;
    store_data_in = $urandom; size_in = 2'($urandom); load_unsigned_in = 1'($urandom);
    hready_in = 1'($urandom); dmdata_in = $urandom;
  endtask

  // Reference rules: access width in bytes, natural alignment, lane mask and replication.
  function automatic void model(input logic [31:0] addr, input logic [31:0] data,
                                input logic [1:0] size, output logic [3:0] mask,
                                output logic [31:0] wdata, output bit mis);
    int nbytes;
    int off;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off    = int'(addr[1:0]);
    mis    = (off % nbytes) != 0;
    mask   = 4'(((1 << nbytes) - 1) << off);
    if (nbytes == 1)      wdata = (data & 32'h0000_00FF) * 32'h0101_0101;
    else if (nbytes == 2) wdata = (data & 32'h0000_FFFF) * 32'h0001_0001;
    else                  wdata = data;
  endfunction

  // One full transaction starting from IDLE; returns with the next cycle in IDLE.
  task automatic txn(input bit ld, input bit st, input logic [31:0] addr, input logic [31:0] data,
                     input logic [1:0] size, input bit uns, input int dly, input logic [31:0] rdata,
                     input logic [3:0] emask, input logic [31:0] ewdata, input bit emis);
    next_cycle();
    load_req_in = ld; store_req_in = st; addr_in = addr; store_data_in = data;
    size_in = size; load_unsigned_in = uns; hready_in = 1'($urandom); dmdata_in = $urandom;
    #3;
    chkb("stall_on_req", stall_out, 1'b1);
    chkb("rd_req_idle", rd_req_out, 1'b0);
    chkb("wr_req_idle", wr_req_out, 1'b0);
    if (emis) begin
      next_cycle(); junk_inputs(); #3;
      chkb("misaligned", misaligned_out, 1'b1);
      chkb("stall_err", stall_out, 1'b1);
      chkb("rd_req_err", rd_req_out, 1'b0);
      chkb("wr_req_err", wr_req_out, 1'b0);
      chkb("bus_err_err", bus_err_out, 1'b0);
      chk("lu_data_err", lu_data_out, exp_lu);
      idle_inputs();
      return;
    end
    for (int k = 0; k <= dly; k++) begin
      next_cycle(); junk_inputs();
      hready_in = (k == dly);
      dmdata_in = (k == dly) ? rdata : $urandom;
      #3;
      chkb("rd_req_busy", rd_req_out, !st);
      chkb("wr_req_busy", wr_req_out, st);
      chk("dmaddr", dmaddr_out, addr & 32'hFFFF_FFFC);
      chk("mask", {28'h0, mask_out}, {28'h0, st ? emask : 4'h0});
      chkb("stall_busy", stall_out, 1'b1);
      chkb("done_busy", done_out, 1'b0);
      if (st) chk("dmdata_out", dmdata_out, ewdata);
    end
    next_cycle(); junk_inputs(); #3;
    if (!st) exp_lu = rdata;
    chkb("done", done_out, 1'b1);
    chkb("stall_done", stall_out, 1'b0);
    chkb("rd_req_done", rd_req_out, 1'b0);
    chkb("wr_req_done", wr_req_out, 1'b0);
    chkb("misaligned_done", misaligned_out, 1'b0);
    chk("lu_data", lu_data_out, exp_lu);
    chk("load_size", {30'h0, load_size_out}, {30'h0, size});
    chkb("load_unsigned", load_unsigned_out, uns);
    chk("iadder", {30'h0, iadder_out}, {30'h0, addr[1:0]});
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    tbl[0] = '{1'b1, 1'b0, 32'h100, 32'h0,        2'b10, 1'b0, 2, 32'hDEADBEEF, 4'h0, 32'h0,        1'b0};
    tbl[1] = '{1'b0, 1'b1, 32'h203, 32'h000000A5, 2'b00, 1'b0, 0, 32'h0,        4'h8, 32'hA5A5A5A5, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 32'h302, 32'h00001234, 2'b01, 1'b0, 1, 32'h0,        4'hC, 32'h12341234, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 32'h301, 32'h0,        2'b01, 1'b0, 0, 32'h0,        4'h0, 32'h0,        1'b1};
    tbl[4] = '{1'b1, 1'b1, 32'h040, 32'hCAFEF00D, 2'b10, 1'b0, 1, 32'h55555555, 4'hF, 32'hCAFEF00D, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 32'h007, 32'h0,        2'b00, 1'b1, 0, 32'h11223344, 4'h0, 32'h0,        1'b0};
    tbl[6] = '{1'b0, 1'b1, 32'h006, 32'h12345678, 2'b10, 1'b0, 0, 32'h0,        4'h0, 32'h0,        1'b1};
    tbl[7] = '{1'b1, 1'b0, 32'h010, 32'h0,        2'b11, 1'b0, 0, 32'h87654321, 4'h0, 32'h0,        1'b0};
    tbl[8] = '{1'b0, 1'b1, 32'h014, 32'h89ABCDEF, 2'b11, 1'b0, 2, 32'h0,        4'hF, 32'h89ABCDEF, 1'b0};
    tbl[9] = '{1'b0, 1'b1, 32'h000, 32'hFFFFBEEF, 2'b01, 1'b0, 0, 32'h0,        4'h3, 32'hBEEFBEEF, 1'b0};

    idle_inputs();
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    cur = "reset";
    chk("dmaddr", dmaddr_out, 32'h0);
    chk("dmdata", dmdata_out, 32'h0);
    chk("lu_data", lu_data_out, 32'h0);
    chk("mask", {28'h0, mask_out}, 32'h0);
    chk("load_size", {30'h0, load_size_out}, 32'h0);
    chk("iadder", {30'h0, iadder_out}, 32'h0);
    chkb("rd_req", rd_req_out, 1'b0);
    chkb("wr_req", wr_req_out, 1'b0);
    chkb("load_unsigned", load_unsigned_out, 1'b0);
    chkb("stall", stall_out, 1'b0);
    chkb("done", done_out, 1'b0);
    chkb("misaligned", misaligned_out, 1'b0);
    chkb("bus_err", bus_err_out, 1'b0);
    rst = 1'b0;
    exp_lu = 32'h0;

    for (int i = 0; i < 10; i++) begin
      cur = $sformatf("vec%0d", i);
      txn(tbl[i].ld, tbl[i].st, tbl[i].addr, tbl[i].data, tbl[i].size, tbl[i].uns,
          tbl[i].dly, tbl[i].rdata, tbl[i].emask, tbl[i].ewdata, tbl[i].emis);
    end

    cur = "reset_busy";
    next_cycle();
    load_req_in = 1'b1; addr_in = 32'h600; size_in = 2'b10;
    #3 chkb("stall_req", stall_out, 1'b1);
    next_cycle(); idle_inputs(); #3;
    chkb("rd_req_before", rd_req_out, 1'b1);
    #1 rst = 1'b1;
    #1;
    exp_lu = 32'h0;
    chkb("rd_req_after", rd_req_out, 1'b0);
    chkb("stall_after", stall_out, 1'b0);
    chkb("done_after", done_out, 1'b0);
    chk("lu_data_after", lu_data_out, exp_lu);
    #1 rst = 1'b0;
    cur = "after_reset";
    txn(1'b1, 1'b0, 32'h604, 32'h0, 2'b10, 1'b0, 1, 32'h0BADF00D, 4'h0, 32'h0, 1'b0);

    cur = "no_ack";
    next_cycle();
    load_req_in = 1'b1; addr_in = 32'h500; size_in = 2'b10;
    #3 chkb("stall_req", stall_out, 1'b1);
`ifdef MSRV32_DMEM_TIMEOUT_EN
    for (int k = 0; k < TMO; k++) begin
      next_cycle(); idle_inputs(); #3;
      chkb("rd_req_wait", rd_req_out, 1'b1);
      chkb("bus_err_wait", bus_err_out, 1'b0);
    end
    next_cycle(); #3;
    chkb("bus_err", bus_err_out, 1'b1);
    chkb("rd_req_dropped", rd_req_out, 1'b0);
    chkb("stall_err", stall_out, 1'b1);
    chkb("misaligned_err", misaligned_out, 1'b0);
    chk("lu_data_err", lu_data_out, exp_lu);
    next_cycle(); #3;
    chkb("bus_err_clear", bus_err_out, 1'b0);
    chkb("stall_idle", stall_out, 1'b0);
`else
    for (int k = 0; k < 20; k++) begin
      next_cycle(); idle_inputs(); #3;
      chkb("rd_req_wait", rd_req_out, 1'b1);
      chkb("bus_err_wait", bus_err_out, 1'b0);
    end
    next_cycle(); hready_in = 1'b1; dmdata_in = 32'h13579BDF; #3;
    chkb("rd_req_last", rd_req_out, 1'b1);
    next_cycle(); idle_inputs(); #3;
    exp_lu = 32'h13579BDF;
    chkb("done", done_out, 1'b1);
    chk("lu_data", lu_data_out, exp_lu);
`endif

    cur = "rand";
    for (int i = 0; i < 40; i++) begin
      bit          ld, st, uns, mis;
      logic [31:0] a, d, rdat, wd;
      logic [1:0]  sz;
      logic [3:0]  m;
      int          dly;
      ld   = 1'($urandom);
      st   = 1'($urandom);
      if (!ld && !st) ld = 1'b1;
      a    = $urandom & 32'h0000_FFFF;
      d    = $urandom;
      sz   = 2'($urandom);
      uns  = 1'($urandom);
      dly  = int'($urandom_range(0, 3));
      rdat = $urandom;
      model(a, d, sz, m, wd, mis);
      cur  = $sformatf("rand%0d", i);
      txn(ld, st, a, d, sz, uns, dly, rdat, m, wd, mis);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
